// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory handshake, next-PC feedback and decode-side outputs.
interface fetch_ctrl_if;
    logic [31:0] niaddr;
    logic        stall;
    logic        exc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] icount;
    logic [31:0] epc;

    modport master (
        input  niaddr, stall, exc, imem_ack, imem_rdata,
        output imem_req, imem_addr, iaddr, instr, instr_valid, icount, epc
    );

    modport slave (
        output niaddr, stall, exc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, iaddr, instr, instr_valid, icount, epc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, fetches one word per instruction, counts retirements.
// Optional exception redirect and DRAIN state enabled by defining FETCH_CTRL_EXC_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic           clk,
    input  logic           rst,
    fetch_ctrl_if.master   bus
);

`ifdef FETCH_CTRL_EXC_EN
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_ISSUE} state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_iaddr;
    logic [31:0] w_next_iaddr;
    logic [31:0] r_instr;
    logic [31:0] w_next_instr;
    logic        r_instr_valid;
    logic        w_next_valid;
    logic [31:0] r_icount;
    logic [31:0] w_next_icount;
    logic [31:0] r_epc;
    logic [31:0] w_next_epc;
    logic        w_exc;
    logic [31:0] w_niaddr_aligned;

`ifdef FETCH_CTRL_EXC_EN
    assign w_exc = bus.exc;
`else
    assign w_exc = 1'b0;
`endif

    assign w_niaddr_aligned = bus.niaddr & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_iaddr       <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_icount      <= 32'h0;
            r_epc         <= 32'h0;
        end else begin
            r_state       <= w_next_state;
            r_iaddr       <= w_next_iaddr;
            r_instr       <= w_next_instr;
            r_instr_valid <= w_next_valid;
            r_icount      <= w_next_icount;
            r_epc         <= w_next_epc;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_iaddr  = r_iaddr;
        w_next_instr  = r_instr;
        w_next_valid  = r_instr_valid;
        w_next_icount = r_icount;
        w_next_epc    = r_epc;
        case (r_state)
            S_FETCH: begin
                if (w_exc) begin
                    w_next_epc   = r_iaddr;
                    w_next_iaddr = EXC_VEC;
`ifdef FETCH_CTRL_EXC_EN
                    // A same-cycle ack retires the outstanding request, so no drain is needed.
                    w_next_state = bus.imem_ack ? S_FETCH : S_DRAIN;
`endif
                end else if (bus.imem_ack) begin
                    w_next_instr = bus.imem_rdata;
                    w_next_valid = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_exc) begin
                    w_next_epc   = r_iaddr;
                    w_next_iaddr = EXC_VEC;
                    w_next_valid = 1'b0;
                    w_next_state = S_FETCH;
                end else if (!bus.stall) begin
                    w_next_iaddr  = w_niaddr_aligned;
                    w_next_icount = r_icount + 32'd1;
                    w_next_valid  = 1'b0;
                    w_next_state  = S_FETCH;
                end
            end
`ifdef FETCH_CTRL_EXC_EN
            S_DRAIN: begin
                if (w_exc) begin
                    w_next_epc   = r_iaddr;
                    w_next_iaddr = EXC_VEC;
                end else if (bus.imem_ack) begin
                    w_next_state = S_FETCH;
                end
            end
`endif
            default: begin
                w_next_state = S_FETCH;
                w_next_valid = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_iaddr;
    assign bus.iaddr       = r_iaddr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.icount      = r_icount;
`ifdef FETCH_CTRL_EXC_EN
    assign bus.epc         = r_epc;
`else
    assign bus.epc         = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshake latency, stall, branch alignment, memory wait, exception, reset.
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC(32'h0000_3000),
        .EXC_VEC (32'h0000_4180)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus.niaddr     = 32'h0;
        bus.stall      = 1'b0;
        bus.exc        = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_iaddr",  bus.iaddr, 32'h0000_3000);
        chk("rst_valid",  {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_instr",  bus.instr, 32'h0);
        chk("rst_icount", bus.icount, 32'h0);
        chk("rst_epc",    bus.epc, 32'h0);
        rst = 1'b0;

        // Zero-wait fetch then immediate consume
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2402_0001;
        bus.niaddr     = 32'h0000_3004;
        chk("t1_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("t1_addr", bus.imem_addr, 32'h0000_3000);
        tick();
        bus.imem_ack = 1'b0;
        chk("t1_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("t1_instr", bus.instr, 32'h2402_0001);
        chk("t1_req_issue", {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk("t1_valid_low", {31'h0, bus.instr_valid}, 32'h0);
        chk("t1_addr2", bus.imem_addr, 32'h0000_3004);
        chk("t1_req2",  {31'h0, bus.imem_req}, 32'h1);
        chk("t1_icount", bus.icount, 32'd1);

        // Stall held 3 cycles; acks in ISSUE are ignored
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hAAAA_0001;
        tick();
        bus.stall      = 1'b1;
        bus.niaddr     = 32'h0000_3008;
        bus.imem_rdata = 32'hBBBB_0002;
        for (int i = 0; i < 3; i++) begin
            chk("t2_valid",  {31'h0, bus.instr_valid}, 32'h1);
            chk("t2_instr",  bus.instr, 32'hAAAA_0001);
            chk("t2_iaddr",  bus.iaddr, 32'h0000_3004);
            chk("t2_icount", bus.icount, 32'd1);
            tick();
        end
        bus.stall    = 1'b0;
        bus.imem_ack = 1'b0;
        chk("t2_valid4", {31'h0, bus.instr_valid}, 32'h1);
        chk("t2_instr4", bus.instr, 32'hAAAA_0001);
        tick();
        chk("t2_iaddr_next", bus.iaddr, 32'h0000_3008);
        chk("t2_icount_next", bus.icount, 32'd2);

        // Branch target, then misaligned target forced to word alignment
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1000_0003;
        tick();
        bus.imem_ack = 1'b0;
        bus.niaddr   = 32'h0000_2FF0;
        tick();
        chk("t3_branch", bus.iaddr, 32'h0000_2FF0);
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        bus.niaddr   = 32'h0000_3013;
        tick();
        chk("t3_align", bus.iaddr, 32'h0000_3010);
        chk("t3_icount", bus.icount, 32'd4);

        // Four wait cycles before ack
        for (int i = 0; i < 4; i++) begin
            chk("t4_req_wait",  {31'h0, bus.imem_req}, 32'h1);
            chk("t4_addr_wait", bus.imem_addr, 32'h0000_3010);
            chk("t4_valid_wait", {31'h0, bus.instr_valid}, 32'h0);
            tick();
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h3C01_0004;
        chk("t4_req_ack",  {31'h0, bus.imem_req}, 32'h1);
        chk("t4_addr_ack", bus.imem_addr, 32'h0000_3010);
        tick();
        bus.imem_ack = 1'b0;
        bus.niaddr   = 32'h0000_3008;
        chk("t4_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("t4_instr", bus.instr, 32'h3C01_0004);
        tick();
        chk("t4_iaddr",  bus.iaddr, 32'h0000_3008);
        chk("t4_icount", bus.icount, 32'd5);

`ifdef FETCH_CTRL_EXC_EN
        // Exception in FETCH, stale ack two cycles later is drained
        bus.exc = 1'b1;
        tick();
        bus.exc = 1'b0;
        chk("t5_epc",   bus.epc, 32'h0000_3008);
        chk("t5_iaddr", bus.iaddr, 32'h0000_4180);
        chk("t5_req_drain", {31'h0, bus.imem_req}, 32'h0);
        chk("t5_valid_drain", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        chk("t5_req_drain2", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("t5_valid_drop", {31'h0, bus.instr_valid}, 32'h0);
        chk("t5_instr_drop", bus.instr, 32'h3C01_0004);
        chk("t5_req_refetch", {31'h0, bus.imem_req}, 32'h1);
        chk("t5_addr_refetch", bus.imem_addr, 32'h0000_4180);
        chk("t5_icount", bus.icount, 32'd5);
`else
        // Exception pulses are ignored in FETCH and ISSUE
        bus.exc = 1'b1;
        tick();
        bus.exc = 1'b0;
        chk("t5_req_noexc",  {31'h0, bus.imem_req}, 32'h1);
        chk("t5_addr_noexc", bus.imem_addr, 32'h0000_3008);
        chk("t5_epc_zero",   bus.epc, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0800_0005;
        tick();
        bus.imem_ack = 1'b0;
        bus.exc      = 1'b1;
        bus.stall    = 1'b1;
        tick();
        bus.exc   = 1'b0;
        bus.stall = 1'b0;
        bus.niaddr = 32'h0000_300C;
        chk("t5_valid_noexc", {31'h0, bus.instr_valid}, 32'h1);
        chk("t5_iaddr_noexc", bus.iaddr, 32'h0000_3008);
        chk("t5_epc_zero2",   bus.epc, 32'h0);
        tick();
        chk("t5_iaddr_after", bus.iaddr, 32'h0000_300C);
        chk("t5_icount", bus.icount, 32'd6);
`endif

        // Reset in FETCH coinciding with an ack
        chk("t6_req_pre", {31'h0, bus.imem_req}, 32'h1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        chk("t6_iaddr",  bus.iaddr, 32'h0000_3000);
        chk("t6_valid",  {31'h0, bus.instr_valid}, 32'h0);
        chk("t6_instr",  bus.instr, 32'h0);
        chk("t6_icount", bus.icount, 32'h0);
        chk("t6_epc",    bus.epc, 32'h0);
        chk("t6_req",    {31'h0, bus.imem_req}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller that owns the program counter and sequences instruction fetch around the next-PC logic. It holds `iaddr`, issues word fetches to instruction memory over a req/ack handshake, presents the fetched instruction to decode, and loads the `niaddr` produced by the next-PC block when decode consumes the instruction. It sits between instruction memory, the next-PC block and the decode stage, and also counts retired instructions.

## Interface

- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `EXC_VEC`, 32'h0000_4180: exception redirect target (used only with `FETCH_CTRL_EXC_EN`).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `niaddr`  in  32  next instruction address from the next-PC block (PC+4, branch or jump target).
- `stall`  in  1  decode/execute cannot accept the presented instruction this cycle.
- `exc`  in  1  exception request, single-cycle pulse.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `iaddr`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `iaddr`  out  32  current PC, fed to the next-PC block.
- `instr`  out  32  registered instruction word.
- `instr_valid`  out  1  `instr` is valid for `iaddr`.
- `icount`  out  32  retired-instruction counter.
- `epc`  out  32  address of the instruction interrupted by the last exception.

## Operation

- States: FETCH, ISSUE, DRAIN.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_valid`<=1, go to ISSUE.
- ISSUE:
  - `imem_req`=0 and `instr_valid`=1.
  - Consume is `instr_valid & ~stall`.
  - On consume: `iaddr`<={`niaddr`[31:2],2'b00}, `icount`<=`icount`+1 (wraps at 2^32), `instr_valid`<=0, go to FETCH.
  - While `stall`=1: `instr`, `iaddr` and `instr_valid` hold.
- DRAIN:
  - `imem_req`=0 and `instr_valid`=0.
  - DRAIN discards one outstanding response.
  - On `imem_ack`: drop the data and go to FETCH.
- `imem_ack` is ignored in ISSUE.
- `niaddr` is sampled only on the consume edge.
- `iaddr`[1:0] is always 00.

Exception handling (`FETCH_CTRL_EXC_EN`):
- `exc` has priority over consume and over `imem_ack`.
- `exc` in ISSUE:
  - `epc`<=`iaddr`, `iaddr`<=`EXC_VEC`, `instr_valid`<=0, go to FETCH.
  - `icount` is not incremented.
- `exc` in FETCH:
  - `epc`<=`iaddr`, `iaddr`<=`EXC_VEC`.
  - If `imem_ack` is also 1 that cycle, go to FETCH and drop the data.
  - Otherwise go to DRAIN.
- `exc` in DRAIN: `epc` and `iaddr` are updated again; stay in DRAIN.

## Timing

- Reset values:
  - State FETCH, `iaddr`=`RESET_PC`, `instr`=0, `instr_valid`=0, `icount`=0, `epc`=0.
  - `imem_req`=1 from the first cycle after reset release.
- `imem_req` and `imem_addr` are combinational from state and `iaddr`.
- `imem_addr` is stable while `imem_req`=1.
- Memory may ack in the same cycle `imem_req` is first high (zero wait) or any later cycle.
- `imem_ack` is sampled only while `imem_req`=1 or in DRAIN.
- Latency:
  - Ack in cycle N gives `instr_valid`=1 in cycle N+1.
  - Consume in cycle M gives new `iaddr` and `imem_req`=1 in cycle M+1.
  - Minimum is 2 cycles per instruction.
- `rst` in any state, including mid-fetch, returns all outputs to their reset values on the next edge. A pending ack in the reset cycle is ignored.

## Configuration

- `FETCH_CTRL_EXC_EN` defined: the exception path and DRAIN state are as described above.
- `FETCH_CTRL_EXC_EN` undefined:
  - `exc` is ignored.
  - `epc` is tied to 0.
  - DRAIN is not implemented.
  - `EXC_VEC` is unused.

## Test plan

- Reset release, memory acks zero-wait with 32'h2402_0001, `niaddr`=32'h0000_3004, `stall`=0:
  - `imem_addr` reads 32'h0000_3000, then `instr_valid` is high for 1 cycle, then `imem_addr` reads 32'h0000_3004.
  - `icount`=1.
- `stall` held 3 cycles in ISSUE: `instr`, `iaddr` and `instr_valid` are unchanged for 3 cycles, `icount` does not increment, consume happens on the 4th cycle.
- Branch: `niaddr`=32'h0000_2FF0 at consume gives `iaddr`=32'h0000_2FF0 next cycle. `niaddr`=32'h0000_3013 gives `iaddr`=32'h0000_3010.
- Memory wait of 4 cycles: `imem_req` stays high with a stable address for 5 cycles, and `instr_valid` rises 1 cycle after ack.
- With `FETCH_CTRL_EXC_EN`, `exc` pulsed in FETCH at `iaddr`=32'h0000_3008 with ack 2 cycles later:
  - `epc`=32'h0000_3008.
  - The late ack data is dropped and `instr_valid` stays 0.
  - Next fetch is at 32'h0000_4180.
  - `icount` is unchanged.
- `rst` asserted in FETCH while the ack arrives: after release, `iaddr`=`RESET_PC`, `instr_valid`=0 and `icount`=0. Same test without the macro: `exc` pulses have no effect and `epc`=0.
